// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversion.
// The conversion functions work on a 32-bit container so any pointer width up to
// 32 bits can use them; callers zero-extend on the way in and truncate on the way out.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 5;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int MAX_PTR_WIDTH       = 32;

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; leading zeros of a
  // zero-extended pointer therefore leave the result unchanged.
  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] gray);
    logic [MAX_PTR_WIDTH-1:0] bin;
    bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
// Plain flop chain with nothing between stages, so only metastability settling time
// separates the input from the output. Used on both the read and write sides.
module ptr_sync #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Shift the asynchronous pointer through the chain; reset clears every stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain pointer controller of the async FIFO. Brings the write pointer into
// Rd_clk, advances the binary/Gray read pointer on accepted reads, and registers the
// empty flag, occupancy estimate, read-valid strobe and sticky underflow flag.
// Empty is computed from the next read pointer so the edge that consumes the last
// entry also raises Empty_sig, preventing a back-to-back overread.
module rd_ptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int Addr_width  = DEFAULT_ADDR_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  Rd_clk,
  input  logic                  rst,
  input  logic                  Rd_inc,
  input  logic [Addr_width:0]   Wr_point_gray,
  output logic [Addr_width-1:0] Rd_addr,
  output logic [Addr_width:0]   Rd_point,
  output logic [Addr_width:0]   Synch_Wr_point,
  output logic                  Empty_sig,
  output logic                  Rd_accept,
  output logic                  Rd_valid,
  output logic                  Underflow,
  output logic [Addr_width:0]   Rd_level
);

  localparam int PTR_W = Addr_width + 1;

  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_next;
  logic [PTR_W-1:0] rd_gray_next;
  logic [PTR_W-1:0] wr_bin_sync;
  logic [PTR_W-1:0] level_next;

  ptr_sync #(
    .WIDTH       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clock (Rd_clk),
    .reset (rst),
    .d     (Wr_point_gray),
    .q     (Synch_Wr_point)
  );

  assign Rd_accept = Rd_inc & ~Empty_sig;
  assign Rd_addr   = rd_bin[Addr_width-1:0];

  // Next-pointer arithmetic: increment on accept, Gray-encode, and estimate occupancy.
  always_comb begin
    rd_bin_next  = rd_bin + {{(PTR_W-1){1'b0}}, Rd_accept};
    rd_gray_next = PTR_W'(bin2gray(MAX_PTR_WIDTH'(rd_bin_next)));
    wr_bin_sync  = PTR_W'(gray2bin(MAX_PTR_WIDTH'(Synch_Wr_point)));
    level_next   = wr_bin_sync - rd_bin_next;
  end

  // Pointer, empty and level registers; Rd_point comes straight from a flop.
  always_ff @(posedge Rd_clk) begin
    if (rst) begin
      rd_bin    <= '0;
      Rd_point  <= '0;
      Empty_sig <= 1'b1;
      Rd_level  <= '0;
    end else begin
      rd_bin    <= rd_bin_next;
      Rd_point  <= rd_gray_next;
      Empty_sig <= (rd_gray_next == Synch_Wr_point);
      Rd_level  <= level_next;
    end
  end

  // Read-data valid follows the RAM's one-cycle latency; underflow latches until reset.
  always_ff @(posedge Rd_clk) begin
    if (rst) begin
      Rd_valid  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Rd_valid  <= Rd_accept;
      Underflow <= Underflow | (Rd_inc & Empty_sig);
    end
  end

endmodule
